skeleton_math_ctrl: RTL and testbench



---
 rtl/skeleton_math_ctrl_if.sv | 42 ++++
 rtl/skeleton_math_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_skeleton_math_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/skeleton_math_ctrl_if.sv
// Bundle of the host-side word streams, the skeleton register bus and the status
// flags around skeleton_math_ctrl.
//   master : controller view (drives s_ready, m_*, dut_* controls, busy, err_timeout)
//   slave  : environment view (host streams plus the skeleton wrapper)
// Signals:
//   s_data/s_valid/s_ready   operand stream from the host
//   m_data/m_valid/m_ready   result stream to the host
//   dut_en/dut_trgg/dut_rnw/dut_adr/dut_din  skeleton controls
//   dut_dout/dut_rdy         skeleton result and ready
//   busy/err_timeout         frame in progress, sticky RDY timeout
interface skeleton_math_ctrl_if #(
    parameter int unsigned BITWIDTH_SYS = 16,
    parameter int unsigned BITWIDTH_ADR = 6
);
    logic [BITWIDTH_SYS-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [BITWIDTH_SYS-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    dut_en;
    logic                    dut_trgg;
    logic                    dut_rnw;
    logic [BITWIDTH_ADR-1:0] dut_adr;
    logic [BITWIDTH_SYS-1:0] dut_din;
    logic [BITWIDTH_SYS-1:0] dut_dout;
    logic                    dut_rdy;
    logic                    busy;
    logic                    err_timeout;

    modport master (
        input  s_data, s_valid, m_ready, dut_dout, dut_rdy,
        output s_ready, m_data, m_valid, dut_en, dut_trgg, dut_rnw, dut_adr,
               dut_din, busy, err_timeout
    );

    modport slave (
        output s_data, s_valid, m_ready, dut_dout, dut_rdy,
        input  s_ready, m_data, m_valid, dut_en, dut_trgg, dut_rnw, dut_adr,
               dut_din, busy, err_timeout
    );
endinterface

// File: rtl/skeleton_math_ctrl.sv
// Sequencer for the register-bus side of a math-test skeleton. Loads SIZE_INPUT
// operand words into the skeleton RAM, fires NUM_TRIGGERS start pulses, waits for
// RDY (bounded by TIMEOUT) and returns the result word on the host stream.
// Ports:
//   clk_sys  system clock
//   rstn     asynchronous active-low reset
//   bus      skeleton_math_ctrl_if.master (host streams, skeleton bus, status)
// Optional feature macro CTRL_CYCLE_COUNT_EN: a 16-bit saturating cycle counter
// covering the trigger/wait phase is sent as a second word after the result.
module skeleton_math_ctrl #(
    parameter int unsigned BITWIDTH_SYS = 16,
    parameter int unsigned BITWIDTH_ADR = 6,
    parameter int unsigned SIZE_INPUT   = 2,
    parameter int unsigned NUM_TRIGGERS = 2,
    parameter int unsigned TRIG_LEN     = 1,
    parameter int unsigned RESULT_LAT   = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input logic                 clk_sys,
    input logic                 rstn,
    skeleton_math_ctrl_if.master bus
);

    localparam int unsigned TL_W  = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
    localparam int unsigned LAT_W = (RESULT_LAT > 0) ? $clog2(RESULT_LAT + 1) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned PC_W  = 3;
    localparam int unsigned CYC_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TRIG_HI,
        ST_TRIG_LO,
        ST_WAIT,
        ST_CAPTURE,
        ST_SEND
    } state_t;

    state_t state, state_next;

    logic [BITWIDTH_ADR-1:0] widx, widx_next;
    logic [TL_W-1:0]         tlcnt, tlcnt_next;
    logic [PC_W-1:0]         pcnt, pcnt_next;
    logic [LAT_W-1:0]        lcnt, lcnt_next;
    logic [TO_W-1:0]         tocnt, tocnt_next;
    logic                    timeout_hit;
    logic                    s_hs;
    logic                    m_hs;

    logic                    s_ready_q, s_ready_d;
    logic [BITWIDTH_SYS-1:0] m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    en_q, en_d;
    logic                    trgg_q, trgg_d;
    logic                    rnw_q, rnw_d;
    logic [BITWIDTH_ADR-1:0] adr_q, adr_d;
    logic [BITWIDTH_SYS-1:0] din_q, din_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

`ifdef CTRL_CYCLE_COUNT_EN
    logic [CYC_W-1:0]        cyc, cyc_next;
    logic                    word_sel, word_sel_next;
`endif

    assign s_hs = bus.s_valid && s_ready_q;
    assign m_hs = m_valid_q && bus.m_ready;

    // State, counters and registered outputs
    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            widx      <= '0;
            tlcnt     <= '0;
            pcnt      <= '0;
            lcnt      <= '0;
            tocnt     <= '0;
            s_ready_q <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            en_q      <= 1'b0;
            trgg_q    <= 1'b0;
            rnw_q     <= 1'b1;
            adr_q     <= '0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CTRL_CYCLE_COUNT_EN
            cyc       <= '0;
            word_sel  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            widx      <= widx_next;
            tlcnt     <= tlcnt_next;
            pcnt      <= pcnt_next;
            lcnt      <= lcnt_next;
            tocnt     <= tocnt_next;
            s_ready_q <= s_ready_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            en_q      <= en_d;
            trgg_q    <= trgg_d;
            rnw_q     <= rnw_d;
            adr_q     <= adr_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef CTRL_CYCLE_COUNT_EN
            cyc       <= cyc_next;
            word_sel  <= word_sel_next;
`endif
        end
    end

    // Next state and counter updates
    always_comb begin
        state_next  = state;
        widx_next   = widx;
        tlcnt_next  = tlcnt;
        pcnt_next   = pcnt;
        lcnt_next   = lcnt;
        tocnt_next  = tocnt;
        timeout_hit = 1'b0;
`ifdef CTRL_CYCLE_COUNT_EN
        word_sel_next = word_sel;
`endif
        case (state)
            ST_IDLE, ST_LOAD: begin
                tlcnt_next = '0;
                pcnt_next  = '0;
                lcnt_next  = '0;
                tocnt_next = '0;
                if (s_hs) begin
                    if (widx == BITWIDTH_ADR'(SIZE_INPUT - 1)) begin
                        widx_next  = '0;
                        state_next = ST_TRIG_HI;
                    end else begin
                        widx_next  = widx + BITWIDTH_ADR'(1);
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_TRIG_HI: begin
                if (tlcnt == TL_W'(TRIG_LEN - 1)) begin
                    tlcnt_next = '0;
                    state_next = ST_TRIG_LO;
                end else begin
                    tlcnt_next = tlcnt + TL_W'(1);
                end
            end
            ST_TRIG_LO: begin
                pcnt_next = pcnt + PC_W'(1);
                if (pcnt_next < PC_W'(NUM_TRIGGERS)) begin
                    state_next = ST_TRIG_HI;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Fixed result latency first, then a bounded poll of RDY
                if (lcnt < LAT_W'(RESULT_LAT)) begin
                    lcnt_next = lcnt + LAT_W'(1);
                end else if (bus.dut_rdy) begin
                    state_next = ST_CAPTURE;
                end else if (tocnt == TO_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_CAPTURE;
                end else begin
                    tocnt_next = tocnt + TO_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_next = ST_SEND;
`ifdef CTRL_CYCLE_COUNT_EN
                word_sel_next = 1'b0;
`endif
            end
            ST_SEND: begin
                if (m_hs) begin
`ifdef CTRL_CYCLE_COUNT_EN
                    if (!word_sel) begin
                        word_sel_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef CTRL_CYCLE_COUNT_EN
    // Elapsed cycles from the first trigger cycle up to the cycle that leaves WAIT
    always_comb begin
        cyc_next = cyc;
        case (state)
            ST_IDLE, ST_LOAD: cyc_next = '0;
            ST_TRIG_HI, ST_TRIG_LO, ST_WAIT: begin
                if (state_next != ST_CAPTURE && cyc != {CYC_W{1'b1}}) begin
                    cyc_next = cyc + CYC_W'(1);
                end
            end
            default: cyc_next = cyc;
        endcase
    end
`endif

    // Output values registered at the next edge
    always_comb begin
        s_ready_d = (state_next == ST_IDLE) || (state_next == ST_LOAD);
        busy_d    = (state_next != ST_IDLE);
        en_d      = 1'b1;
        trgg_d    = (state == ST_TRIG_HI);
        rnw_d     = 1'b1;
        adr_d     = adr_q;
        din_d     = din_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        err_d     = err_q | timeout_hit;

        // One write strobe per accepted operand word
        if ((state == ST_IDLE || state == ST_LOAD) && s_hs) begin
            rnw_d = 1'b0;
            adr_d = widx;
            din_d = bus.s_data;
        end

        if (state == ST_CAPTURE) begin
            m_data_d  = bus.dut_dout;
            m_valid_d = 1'b1;
        end

        if (state == ST_SEND && m_hs) begin
`ifdef CTRL_CYCLE_COUNT_EN
            if (!word_sel) begin
                m_data_d = BITWIDTH_SYS'(cyc);
            end else begin
                m_valid_d = 1'b0;
            end
`else
            m_valid_d = 1'b0;
`endif
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.m_data      = m_data_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.dut_en      = en_q;
    assign bus.dut_trgg    = trgg_q;
    assign bus.dut_rnw     = rnw_q;
    assign bus.dut_adr     = adr_q;
    assign bus.dut_din     = din_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_skeleton_math_ctrl.sv
// Scoreboard bench for skeleton_math_ctrl with a behavioural multiplier skeleton.
module tb_skeleton_math_ctrl;
    localparam int unsigned W    = 16;
    localparam int unsigned AW   = 6;
    localparam int unsigned SIZE = 2;
    localparam int unsigned NT   = 2;
    localparam int unsigned TL   = 1;
    localparam int unsigned RL   = 1;
    localparam int unsigned TO   = 255;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [W-1:0]  din;
    } wr_t;

    logic clk_sys = 1'b0;
    logic rstn;
    always #5 clk_sys = ~clk_sys;

    skeleton_math_ctrl_if #(.BITWIDTH_SYS(W), .BITWIDTH_ADR(AW)) bus ();

    skeleton_math_ctrl #(
        .BITWIDTH_SYS(W), .BITWIDTH_ADR(AW), .SIZE_INPUT(SIZE),
        .NUM_TRIGGERS(NT), .TRIG_LEN(TL), .RESULT_LAT(RL), .TIMEOUT(TO)
    ) dut (
        .clk_sys(clk_sys),
        .rstn   (rstn),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q [$];
    wr_t          wr_q  [$];
    logic force_rdy_low = 1'b0;
    logic mr_rand = 1'b0;
    int   pulses = 0;
    logic trgg_prev = 1'b0;
    wr_t  w_mon;
    logic [W-1:0] e_mon;

    // Skeleton model: RAM plus product of the high bytes of words 0 and 1
    logic [W-1:0] ram [0:63];
    always @(posedge clk_sys) if (bus.dut_en && !bus.dut_rnw) ram[bus.dut_adr] <= bus.dut_din;
    assign bus.dut_dout = W'({8'h00, ram[0][15:8]} * {8'h00, ram[1][15:8]});
    assign bus.dut_rdy  = force_rdy_low ? 1'b0 : ~bus.dut_trgg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ha, hb;
        ha = a >> 8;
        hb = b >> 8;
        return W'(ha * hb);
    endfunction

    function automatic int base_lat();
        return NT * (TL + 1) + RL;
    endfunction

    // Monitor: pulse counting, write scoreboard, result scoreboard
    always @(negedge clk_sys) begin
        if (bus.dut_trgg && !trgg_prev) pulses++;
        trgg_prev = bus.dut_trgg;
        if (rstn && !bus.dut_rnw) begin
            check("write_expected", 32'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                w_mon = wr_q.pop_front();
                check("write_adr", 32'(bus.dut_adr), 32'(w_mon.adr));
                check("write_din", 32'(bus.dut_din), 32'(w_mon.din));
            end
        end
        if (rstn && bus.m_valid && bus.m_ready) begin
            check("result_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                check("m_data", 32'(bus.m_data), 32'(e_mon));
            end
        end
    end

    initial forever begin
        @(posedge clk_sys);
        #1;
        if (mr_rand) bus.m_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input int gap);
        int   n;
        logic hs;
        n = 0;
        hs = 1'b0;
        bus.s_valid = 1'b0;
        repeat (gap) step();
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!hs && n < 200) begin
            @(negedge clk_sys);
            hs = bus.s_ready;
            step();
            n++;
        end
        bus.s_valid = 1'b0;
        check("s_handshake", 32'(hs), 1);
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready", 32'(bus.s_ready), 0);
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_m_data", 32'(bus.m_data), 0);
        check("rst_dut_en", 32'(bus.dut_en), 0);
        check("rst_dut_trgg", 32'(bus.dut_trgg), 0);
        check("rst_dut_rnw", 32'(bus.dut_rnw), 1);
        check("rst_dut_adr", 32'(bus.dut_adr), 0);
        check("rst_dut_din", 32'(bus.dut_din), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_err", 32'(bus.err_timeout), 0);
    endtask

    task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                             input bit timeout_case, input int hold);
        int p0, lat, n;
        wr_q.push_back('{adr: AW'(0), din: a});
        wr_q.push_back('{adr: AW'(1), din: b});
        exp_q.push_back(model_result(a, b));
`ifdef CTRL_CYCLE_COUNT_EN
        exp_q.push_back(W'(base_lat() + (timeout_case ? int'(TO) : 1) - 1));
`endif
        if (hold > 0) bus.m_ready = 1'b0;
        p0 = pulses;
        send_word(a, gap);
        send_word(b, gap);
        lat = 0;
        if (timeout_case) begin
            while (!bus.err_timeout && lat < 2000) begin step(); lat++; end
            check("timeout_latency", 32'(lat), 32'(base_lat() + int'(TO)));
        end else begin
            while (!bus.m_valid && lat < 2000) begin step(); lat++; end
            check("result_latency", 32'(lat), 32'(base_lat() + 2));
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                step();
                check("hold_m_valid", 32'(bus.m_valid), 1);
                check("hold_m_data", 32'(bus.m_data), 32'(model_result(a, b)));
                check("hold_s_ready", 32'(bus.s_ready), 0);
            end
            bus.m_ready = 1'b1;
        end
        n = 0;
        while (bus.busy && n < 2000) begin step(); n++; end
        check("frame_done", 32'(bus.busy), 0);
        check("idle_ready", 32'(bus.s_ready), 1);
        check("trigger_pulses", 32'(pulses - p0), 32'(NT));
    endtask

    initial begin
        int n;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        rstn = 1'b0;
        #12;
        check_reset_vals();
        @(negedge clk_sys);
        rstn = 1'b1;
        step();
        check("en_after_reset", 32'(bus.dut_en), 1);
        check("ready_after_reset", 32'(bus.s_ready), 1);
        check("busy_after_reset", 32'(bus.busy), 0);

        // Directed frame, then the same operands with a gap before every word
        run_frame(16'h0300, 16'h0500, 0, 1'b0, 0);
        run_frame(16'h0300, 16'h0500, 1, 1'b0, 0);
        // Result held against a stalled host
        run_frame(16'h0700, 16'h0900, 0, 1'b0, 20);

        // Randomised operands, gaps and host back-pressure
        mr_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_frame(W'($urandom), W'($urandom), int'($urandom_range(0, 2)), 1'b0, 0);
        end
        mr_rand = 1'b0;
        step();
        bus.m_ready = 1'b1;

        // RDY never arrives: timeout flag, result still delivered, flag sticky
        check("err_before_timeout", 32'(bus.err_timeout), 0);
        force_rdy_low = 1'b1;
        run_frame(16'h0200, 16'h0400, 0, 1'b1, 0);
        force_rdy_low = 1'b0;
        check("err_sticky_1", 32'(bus.err_timeout), 1);
        run_frame(16'h0100, 16'h0600, 0, 1'b0, 0);
        check("err_sticky_2", 32'(bus.err_timeout), 1);

        // Reset while the trigger pulse is high aborts the frame
        wr_q.push_back('{adr: AW'(0), din: 16'h0A00});
        wr_q.push_back('{adr: AW'(1), din: 16'h0B00});
        send_word(16'h0A00, 0);
        send_word(16'h0B00, 0);
        n = 0;
        while (!bus.dut_trgg && n < 50) begin @(negedge clk_sys); n++; end
        check("trgg_before_abort", 32'(bus.dut_trgg), 1);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        repeat (2) @(negedge clk_sys);
        rstn = 1'b1;
        step();
        check("ready_after_abort", 32'(bus.s_ready), 1);
        run_frame(16'h0400, 16'h0C00, 0, 1'b0, 0);
        check("err_cleared_by_reset", 32'(bus.err_timeout), 0);

        repeat (4) step();
        check("results_drained", 32'(exp_q.size()), 0);
        check("writes_drained", 32'(wr_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
